// File: rtl/adc_ddr_capture_if.sv
// adc_ddr_capture_if: ADC-side bus and frame outputs of adc_ddr_capture.
// Handshake: valid has no ready. dao/dbo stream every cycle; valid marks the
// cycles belonging to the current frame and first/last qualify its ends. The
// consumer must take every valid sample on the cycle it is presented.
interface adc_ddr_capture_if #(
  parameter int DW = 12
);
  logic [DW-1:0] di;
  logic [DW-1:0] di_b;
  logic          of;
  logic          arm;
  logic          continuous;
  logic [DW-1:0] dao;
  logic [DW-1:0] dbo;
  logic          valid;
  logic          first;
  logic          last;
  logic          busy;
  logic          done;
  logic          ovr;

  // ADC pins and control side
  modport master (
    output di, di_b, of, arm, continuous,
    input  dao, dbo, valid, first, last, busy, done, ovr
  );

  // capture block side
  modport slave (
    input  di, di_b, of, arm, continuous,
    output dao, dbo, valid, first, last, busy, done, ovr
  );
endinterface

// File: rtl/adc_ddr_capture.sv
// adc_ddr_capture: dual-channel ADC capture (DDR or parallel bus), offset-binary
// to two's complement normalisation, and framing into FRAME_LEN-sample frames.
// Optional macro ADC_DDR_CAPTURE_TEST_PATTERN_EN replaces the ADC data with a
// free-running counter (A = count, B = ~count).
// Data pipeline: input register -> format register -> output register, so a
// sample taken at rising edge k is on dao/dbo after edge k+2.
module adc_ddr_capture #(
  parameter int DW         = 12,
  parameter int MUX        = 1,
  parameter int OFFSET_BIN = 0,
  parameter int HOLDOFF    = 4,
  parameter int FRAME_LEN  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  adc_ddr_capture_if.slave   bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_CAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [DW-1:0] MSB_MASK  = (OFFSET_BIN != 0) ? {1'b1, {(DW-1){1'b0}}} : {DW{1'b0}};
  localparam logic [7:0]    HOLD_INIT = 8'(HOLDOFF - 1);
  localparam logic [15:0]   LAST_IDX  = 16'(FRAME_LEN - 1);

  logic [DW-1:0] a_src, b_src;
  logic [DW-1:0] a_fmt_d, b_fmt_d, a_fmt_q, b_fmt_q;
  logic [DW-1:0] dao_q, dbo_q;
  logic          of_q;

`ifdef ADC_DDR_CAPTURE_TEST_PATTERN_EN
  logic [DW-1:0] tp_cnt_d, tp_cnt_q;

  // Test pattern counter advances every cycle
  always_comb tp_cnt_d = tp_cnt_q + {{(DW-1){1'b0}}, 1'b1};

  // Test pattern counter register
  always_ff @(posedge clk) begin
    if (rst) tp_cnt_q <= '0;
    else     tp_cnt_q <= tp_cnt_d;
  end

  assign a_src = tp_cnt_q;
  assign b_src = ~tp_cnt_q;
`else
  logic [DW-1:0] abuf_q;
  logic [DW-1:0] a_raw_d, b_raw_d, a_raw_q, b_raw_q;

  // Channel A half of the DDR word is only present around the falling edge
  always_ff @(negedge clk) begin
    abuf_q <= bus.di;
  end

  // Select A/B sources for the rising-edge input register
  always_comb begin
    a_raw_d = bus.di;
    b_raw_d = bus.di_b;
    if (MUX != 0) begin
      a_raw_d = abuf_q;
      b_raw_d = bus.di;
    end
  end

  // Rising-edge input register aligns both channels
  always_ff @(posedge clk) begin
    if (rst) begin
      a_raw_q <= '0;
      b_raw_q <= '0;
    end else begin
      a_raw_q <= a_raw_d;
      b_raw_q <= b_raw_d;
    end
  end

  assign a_src = a_raw_q;
  assign b_src = b_raw_q;
`endif

  // Offset binary to two's complement is just an MSB flip
  always_comb begin
    a_fmt_d = a_src ^ MSB_MASK;
    b_fmt_d = b_src ^ MSB_MASK;
  end

  // Format register, output register and registered over-range pin
  always_ff @(posedge clk) begin
    if (rst) begin
      a_fmt_q <= '0;
      b_fmt_q <= '0;
      dao_q   <= '0;
      dbo_q   <= '0;
      of_q    <= 1'b0;
    end else begin
      a_fmt_q <= a_fmt_d;
      b_fmt_q <= b_fmt_d;
      dao_q   <= a_fmt_q;
      dbo_q   <= b_fmt_q;
      of_q    <= bus.of;
    end
  end

  state_t      state_d, state_q;
  logic [7:0]  hold_d, hold_q;
  logic [15:0] cnt_d, cnt_q;
  logic        valid_d, first_d, last_d, done_d, busy_d, ovr_d;
  logic        valid_q, first_q, last_q, done_q, busy_q, ovr_q;

  // Frame FSM next state; outputs are computed for the state being entered
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    valid_d = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    if (of_q && (state_q == S_HOLD || state_q == S_CAP)) ovr_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.arm) begin
          state_d = S_HOLD;
          hold_d  = HOLD_INIT;
          ovr_d   = 1'b0;
        end
      end
      S_HOLD: begin
        if (hold_q == 8'd0) begin
          state_d = S_CAP;
          cnt_d   = '0;
          valid_d = 1'b1;
          first_d = 1'b1;
          last_d  = (LAST_IDX == 16'd0);
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      S_CAP: begin
        if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          valid_d = 1'b1;
          last_d  = ((cnt_q + 16'd1) == LAST_IDX);
        end
      end
      S_DONE: begin
        if (bus.continuous || bus.arm) begin
          state_d = S_HOLD;
          hold_d  = HOLD_INIT;
          ovr_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Frame FSM state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.dao   = dao_q;
  assign bus.dbo   = dbo_q;
  assign bus.valid = valid_q;
  assign bus.first = first_q;
  assign bus.last  = last_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.ovr   = ovr_q;
  assign dbg_state = state_q;

endmodule
